// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared state type, NOP constant and address check for the instruction memory (IMEM_PARITY_EN adds a stored parity bit)
package imem_pkg;

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      LOAD  = 2'd1,
      RUN   = 2'd2
   } imem_state_t;

   // addi x0,x0,0: used for the power-up fill and for every faulted fetch
   localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef IMEM_PARITY_EN
   localparam int PAR_W = 1;
`else
   localparam int PAR_W = 0;
`endif

   // Byte address is word aligned and falls inside a DEPTH-word array.
   // Compared at 34 bits so DEPTH*4 never wraps.
   function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth);
      logic [33:0] limit;
      limit = {depth, 2'b00};
      return (addr[1:0] == 2'b00) && ({2'b00, addr} < limit);
   endfunction

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - single-port RAM, synchronous write and registered read, storage not reset
module imem_array #(
   parameter int WORD_W = 32,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem_q [DEPTH];
   logic [WORD_W-1:0] rdata_q;

   // One address serves both ports; read data only moves when re is high so it holds between reads
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
      if (re) begin
         rdata_q <= mem_q[addr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - loadable instruction memory: NOP sweep, image load port, faulting fetch port (IMEM_PARITY_EN adds parity_err)
module instr_mem_loader
   import imem_pkg::*;
#(
   parameter int                 DATA_W   = 32,
   parameter int unsigned        DEPTH    = 256,
   parameter int                 ADDR_W   = $clog2(DEPTH),
   parameter logic [DATA_W-1:0]  NOP_WORD = DATA_W'(NOP)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_en,
   input  logic [31:0]       fetch_addr,
   output logic [DATA_W-1:0] instr_out,
   output logic              instr_valid,
   output logic              fetch_fault,
   input  logic              load_start,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [31:0]       load_addr,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   output logic              load_err,
   output logic              mem_ready
`ifdef IMEM_PARITY_EN
   ,
   output logic              parity_err
`endif
);

   localparam int WORD_W = DATA_W + PAR_W;

   imem_state_t       state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              valid_q, valid_d;
   logic              afault_q, afault_d;
   logic              nop_sel_q, nop_sel_d;
   logic              load_err_q, load_err_d;

   logic              mem_we, mem_re;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata_raw;
   logic [WORD_W-1:0] mem_wdata, mem_rdata;
   logic              fetch_ok, load_ok;
   logic              out_bad;

   assign fetch_ok = addr_ok(fetch_addr, DEPTH);
   assign load_ok  = addr_ok(load_addr, DEPTH);

   // Next-state, array port steering and fetch/load bookkeeping
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      valid_d       = 1'b0;
      afault_d      = 1'b0;
      nop_sel_d     = nop_sel_q;
      load_err_d    = load_err_q;
      mem_we        = 1'b0;
      mem_re        = 1'b0;
      mem_addr      = fetch_addr[ADDR_W+1:2];
      mem_wdata_raw = NOP_WORD;
      load_ready    = 1'b0;
      mem_ready     = 1'b0;
      case (state_q)
         CLEAR: begin
            mem_we   = 1'b1;
            mem_addr = cnt_q;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == ADDR_W'(DEPTH - 1)) begin
               cnt_d   = '0;
               state_d = LOAD;
            end
         end
         LOAD: begin
            load_ready    = 1'b1;
            mem_addr      = load_addr[ADDR_W+1:2];
            mem_wdata_raw = load_data;
            if (load_valid) begin
               if (load_ok) begin
                  mem_we = 1'b1;
               end else begin
                  load_err_d = 1'b1;
               end
               // A dropped final beat still ends the image
               if (load_last) begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            mem_ready = 1'b1;
            if (fetch_en) begin
               valid_d   = 1'b1;
               afault_d  = !fetch_ok;
               nop_sel_d = !fetch_ok;
               mem_re    = fetch_ok;
            end
            // Reload keeps the array contents; only the error flag restarts
            if (load_start) begin
               state_d    = LOAD;
               load_err_d = 1'b0;
            end
         end
         default: begin
            state_d = CLEAR;
            cnt_d   = '0;
         end
      endcase
   end

   // State and fetch-response registers, asynchronously cleared
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= CLEAR;
         cnt_q      <= '0;
         valid_q    <= 1'b0;
         afault_q   <= 1'b0;
         nop_sel_q  <= 1'b1;
         load_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         valid_q    <= valid_d;
         afault_q   <= afault_d;
         nop_sel_q  <= nop_sel_d;
         load_err_q <= load_err_d;
      end
   end

`ifdef IMEM_PARITY_EN
   logic par_bad;

   // Even parity: stored bit makes the total count of ones even
   assign mem_wdata  = {^mem_wdata_raw, mem_wdata_raw};
   assign par_bad    = ^mem_rdata;
   assign out_bad    = nop_sel_q | par_bad;
   assign parity_err = valid_q & ~nop_sel_q & par_bad;
   assign fetch_fault = afault_q | parity_err;
`else
   assign mem_wdata   = mem_wdata_raw;
   assign out_bad     = nop_sel_q;
   assign fetch_fault = afault_q;
`endif

   // nop_sel_q only changes on a request, so a faulted result keeps showing NOP while idle
   assign instr_out   = out_bad ? NOP_WORD : mem_rdata[DATA_W-1:0];
   assign instr_valid = valid_q;
   assign load_err    = load_err_q;

   imem_array #(
      .WORD_W (WORD_W),
      .DEPTH  (int'(DEPTH)),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk   (clk),
      .we    (mem_we),
      .re    (mem_re),
      .addr  (mem_addr),
      .wdata (mem_wdata),
      .rdata (mem_rdata)
   );

endmodule
